// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential double-dabble converter.
// The digit adjust constants live here so the adjust cell and the top
// agree on digit width and the add-3 rule.
package bcd_pkg;

    typedef enum logic {IDLE, SHIFT} bcd_state_t;

    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;
    localparam int         DIGIT_W    = 4;

    // Constant function used at elaboration to check the digit count
    // is large enough for the widest binary input.
    function automatic longint unsigned pow10(input int d);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < d; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the shift-and-add-3 adjust step: a digit of 5 or more
// gets 3 added so that the following left shift carries into the next digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    // Add-3 correction, result kept to 4 bits.
    always_comb begin
        digit_out = (digit_in >= ADJ_THRESH) ? digit_in + ADJ_ADD : digit_in;
    end

endmodule

// File: rtl/bcd_dabble_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock.
// A start request latches bin, N shift cycles follow, then bcd is updated
// and done pulses for one cycle. bcd holds its value until the next result.
// Optional macro BCD_AUTO_EN: free-running mode, the block restarts itself
// every time it is idle and the start input is ignored.
module bcd_dabble_seq
    import bcd_pkg::*;
#(
    parameter int N = 6,
    parameter int D = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N-1:0]     bin,
    output logic             busy,
    output logic             done,
    output logic [4*D-1:0]   bcd
);

    localparam int BW = DIGIT_W * D;
    localparam int CW = $clog2(N + 1);

    // Reject widths the digit count cannot represent.
    if (N < 1 || N > 16) begin : g_bad_n
        $error("bcd_dabble_seq: N must be in 1..16");
    end
    if (pow10(D) <= ((64'd1 << N) - 64'd1)) begin : g_bad_d
        $error("bcd_dabble_seq: D digits too few for N-bit input");
    end

    bcd_state_t      state_q, state_d;
    logic [N-1:0]    shift_q, shift_d;
    logic [BW-1:0]   scratch_q, scratch_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic [BW-1:0]   adj_scratch;
    logic            go;

`ifdef BCD_AUTO_EN
    logic unused_start;
    assign unused_start = start;
    assign go = 1'b1;
`else
    assign go = start;
`endif

    for (genvar g = 0; g < D; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (scratch_q[g*DIGIT_W +: DIGIT_W]),
            .digit_out (adj_scratch[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Next-state logic: accept a request in IDLE, adjust-then-shift in SHIFT,
    // publish the result on the last shift.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    shift_d   = bin;
                    scratch_d = '0;
                    cnt_d     = CW'(N);
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = {adj_scratch[BW-2:0], shift_q[N-1]};
                shift_d   = shift_q << 1;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    bcd_d   = {adj_scratch[BW-2:0], shift_q[N-1]};
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_bcd_dabble_seq.sv
// Testbench for bcd_dabble_seq: a 6-bit instance for the main scenarios and
// a 4-bit instance fed from a down-counter model. Expected BCD values come
// from a decimal digit model (repeated divide by ten).
module tb_bcd_dabble_seq;

    localparam int N  = 6;
    localparam int N4 = 4;
    localparam int D  = 2;

    logic clk = 1'b0;
    logic reset;
    logic start, busy, done;
    logic [N-1:0] bin;
    logic [4*D-1:0] bcd;
    logic start4, busy4, done4;
    logic [N4-1:0] bin4;
    logic [4*D-1:0] bcd4;

    int errors = 0;
    int checks = 0;

    bcd_dabble_seq #(.N(N), .D(D)) dut (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd)
    );

    bcd_dabble_seq #(.N(N4), .D(D)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .bin(bin4),
        .busy(busy4), .done(done4), .bcd(bcd4)
    );

    always #5 clk = ~clk;

    // Decimal digits of v, packed four bits per digit, digit 0 lowest.
    function automatic logic [4*D-1:0] ref_bcd(input int unsigned v);
        int unsigned rem;
        logic [4*D-1:0] r;
        rem = v;
        r = '0;
        for (int k = 0; k < D; k++) begin
            r[k*4 +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; bin = '0; start4 = 1'b0; bin4 = '0;
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (bcd !== 8'h00) begin errors++; $display("[TB] FAIL reset_bcd: got %h expected 00", bcd); end
        checks++; if (bcd4 !== 8'h00) begin errors++; $display("[TB] FAIL reset_bcd4: got %h expected 00", bcd4); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        int lat;
        int busy_cnt;
        @(negedge clk); bin = 6'd63; start = 1'b1;
        @(negedge clk); start = 1'b0; bin = 6'd5;
        lat = 1; busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk); lat++;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL single_timeout: got done=%b expected 1", done); end
        checks++; if (lat - 1 !== N) begin errors++; $display("[TB] FAIL single_latency: got %0d edges expected %0d", lat - 1, N); end
        checks++; if (busy_cnt !== N) begin errors++; $display("[TB] FAIL single_busy_cycles: got %0d expected %0d", busy_cnt, N); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_on_done: got %b expected 0", busy); end
        checks++; if (bcd !== ref_bcd(63)) begin errors++; $display("[TB] FAIL single_bcd: got %h expected %h", bcd, ref_bcd(63)); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL single_done_pulse: got %b expected 0", done); end
        checks++; if (bcd !== ref_bcd(63)) begin errors++; $display("[TB] FAIL single_bcd_hold: got %h expected %h", bcd, ref_bcd(63)); end
    endtask

    task automatic test_back_to_back();
        int vals[$];
        logic [4*D-1:0] exp_q[$];
        logic [4*D-1:0] exp_v;
        int sub, cyc, last_done, ndone;
        vals = '{0, 9, 10, 59};
        for (int i = 0; i < 8; i++) vals.push_back(int'($urandom_range(0, 63)));
        @(negedge clk); bin = N'(vals[0]); start = 1'b1;
        exp_q.push_back(ref_bcd(vals[0]));
        sub = 1; cyc = 0; last_done = -1; ndone = 0;
        while (ndone < vals.size() && cyc < 2000) begin
            @(negedge clk); cyc++;
            if (done) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                checks++; if (bcd !== exp_v) begin errors++; $display("[TB] FAIL b2b_bcd[%0d]: got %h expected %h", ndone, bcd, exp_v); end
                if (last_done >= 0) begin
                    checks++; if (cyc - last_done !== N + 1) begin errors++; $display("[TB] FAIL b2b_spacing[%0d]: got %0d expected %0d", ndone, cyc - last_done, N + 1); end
                end
                last_done = cyc; ndone++;
                if (sub < vals.size()) begin
                    bin = N'(vals[sub]); start = 1'b1;
                    exp_q.push_back(ref_bcd(vals[sub])); sub++;
                end else begin
                    start = 1'b0;
                end
            end else begin
                start = 1'b0;
                bin = N'($urandom);
            end
        end
        start = 1'b0;
        checks++; if (ndone !== vals.size()) begin errors++; $display("[TB] FAIL b2b_count: got %0d results expected %0d", ndone, vals.size()); end
    endtask

    task automatic test_ignore_busy();
        int pulses;
        logic [4*D-1:0] seen;
        @(negedge clk); bin = 6'd42; start = 1'b1;
        @(negedge clk); start = 1'b0; bin = 6'd7;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        pulses = 0; seen = '0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin pulses++; seen = bcd; end
            @(negedge clk);
        end
        checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL ignore_pulses: got %0d expected 1", pulses); end
        checks++; if (seen !== ref_bcd(42)) begin errors++; $display("[TB] FAIL ignore_bcd: got %h expected %h", seen, ref_bcd(42)); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ignore_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_abort();
        int pulses, busy_seen;
        @(negedge clk); bin = 6'd50; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_busy_before: got %b expected 1", busy); end
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done: got %b expected 0", done); end
        checks++; if (bcd !== 8'h00) begin errors++; $display("[TB] FAIL abort_bcd: got %h expected 00", bcd); end
        @(negedge clk); reset = 1'b0;
        pulses = 0; busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) pulses++;
            if (busy) busy_seen++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", pulses); end
        checks++; if (busy_seen !== 0) begin errors++; $display("[TB] FAIL abort_no_busy: got %0d busy cycles expected 0", busy_seen); end
        checks++; if (bcd !== 8'h00) begin errors++; $display("[TB] FAIL abort_bcd_after: got %h expected 00", bcd); end
    endtask

    task automatic test_chain();
        int q, cyc, last_done, ndone, total;
        logic [4*D-1:0] exp_q[$];
        logic [4*D-1:0] exp_v;
        total = 17;
        q = 15;
        @(negedge clk); bin4 = N4'(q); start4 = 1'b1;
        exp_q.push_back(ref_bcd(q));
        q = (q + 15) % 16;
        cyc = 0; last_done = -1; ndone = 0;
        while (ndone < total && cyc < 2000) begin
            @(negedge clk); cyc++;
            if (done4) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                checks++; if (bcd4 !== exp_v) begin errors++; $display("[TB] FAIL chain_bcd[%0d]: got %h expected %h", ndone, bcd4, exp_v); end
                if (last_done >= 0) begin
                    checks++; if (cyc - last_done !== N4 + 1) begin errors++; $display("[TB] FAIL chain_spacing[%0d]: got %0d expected %0d", ndone, cyc - last_done, N4 + 1); end
                end
                last_done = cyc; ndone++;
                if (ndone + exp_q.size() < total) begin
                    bin4 = N4'(q); start4 = 1'b1;
                    exp_q.push_back(ref_bcd(q));
                    q = (q + 15) % 16;
                end else begin
                    start4 = 1'b0;
                end
            end else begin
                start4 = 1'b0;
            end
        end
        start4 = 1'b0;
        checks++; if (ndone !== total) begin errors++; $display("[TB] FAIL chain_count: got %0d results expected %0d", ndone, total); end
    endtask

    task automatic test_auto();
        int cyc, last_done, ndone;
        bin = 6'd37; bin4 = 4'd9; start = 1'b0; start4 = 1'b0;
        cyc = 0; last_done = -1; ndone = 0;
        while (ndone < 6 && cyc < 500) begin
            @(negedge clk); cyc++;
            if (done) begin
                checks++; if (bcd !== ref_bcd(37)) begin errors++; $display("[TB] FAIL auto_bcd[%0d]: got %h expected %h", ndone, bcd, ref_bcd(37)); end
                if (last_done >= 0) begin
                    checks++; if (cyc - last_done !== N + 1) begin errors++; $display("[TB] FAIL auto_spacing[%0d]: got %0d expected %0d", ndone, cyc - last_done, N + 1); end
                end
                last_done = cyc; ndone++;
            end
        end
        checks++; if (ndone !== 6) begin errors++; $display("[TB] FAIL auto_count: got %0d results expected 6", ndone); end
        checks++; if (bcd4 !== ref_bcd(9)) begin errors++; $display("[TB] FAIL auto_bcd4: got %h expected %h", bcd4, ref_bcd(9)); end
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        test_reset();
`ifdef BCD_AUTO_EN
        test_auto();
`else
        test_single();
        test_back_to_back();
        test_ignore_busy();
        test_reset_abort();
        test_chain();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case a scenario never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/bcd_dabble_seq.md
Name: bcd_dabble_seq

Overview:
Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock). It sits directly downstream of the parameterised down-counter and consumes its q value. It produces packed BCD digits for the 7-segment display stage. One conversion is started per request, using a start/busy/done handshake.

Parameters:
N, 6, width of binary input (matches counter width; legal 1..16)
D, 2, number of BCD output digits; must satisfy 10^D > 2^N - 1, enforced by elaboration-time assertion

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
start  input  1  conversion request, sampled on rising clk edge
bin  input  N  binary value to convert (counter q), sampled with start
busy  output  1  high while a conversion is in progress
done  output  1  single-cycle pulse: bcd just updated
bcd  output  4*D  packed BCD result; digit 0 in bits [3:0]; held until next completion

Behaviour:
- Reset (async, active-high): state=IDLE, busy=0, done=0, bcd=0, scratch registers=0, bit counter=0.
- Reset asserted mid-conversion aborts it immediately. bcd is forced to 0 and no done pulse follows.
- States: IDLE, SHIFT.
- IDLE behaviour:
  - done is 0 except for the cycle directly after completion.
  - On an edge with start=1: latch bin into the shift register, clear the scratch BCD, load bit counter=N, set busy=1, go to SHIFT.
- SHIFT, each edge:
  - Apply the adjust step: every scratch digit >= 5 gets +3, each digit kept 4 bits.
  - Then shift {scratch, shift register} left by 1 and decrement the bit counter.
- On the edge where the bit counter goes 1->0:
  - bcd <= shifted scratch.
  - done <= 1 for exactly one cycle.
  - busy <= 0.
  - Go to IDLE.
- Latency: start sampled at edge t, then bcd valid and done=1 in the cycle between edges t+N and t+N+1. busy is high from after edge t until edge t+N.
- start while busy=1 is ignored; no queuing.
- start=1 in the cycle where done=1 (state already IDLE) is accepted. Back-to-back throughput is one result per N+1 cycles.
- bin is only sampled at acceptance; later changes to bin do not affect the conversion in flight.
- Arithmetic: all digit math is unsigned 4-bit. Digits never exceed 9 after the final shift, given the D constraint.

Optional Feature:
- Macro: BCD_AUTO_EN.
- Defined: free-running mode.
  - In IDLE the block self-starts every cycle as if start=1, so the display tracks the counter with N+1 cycles of lag.
  - The start input is ignored. busy/done behave as above.
- Undefined: conversions occur only on an explicit start.

Decomposition:
- Package bcd_pkg holds:
  - typedef enum logic {IDLE, SHIFT} bcd_state_t
  - localparam ADJ_THRESH = 4'd5
  - localparam ADJ_ADD = 4'd3
  - localparam DIGIT_W = 4
- Sub-module bcd_digit_adj: combinational 4-bit adjust (in>=5 ? in+3 : in). Instantiated D times via generate.

Test Plan:
1. N=6, D=2: reset high then low; start=1 one cycle with bin=63. Expect busy=1 for 6 cycles, done pulse once, bcd=8'h63, busy=0 on the done cycle.
2. N=6, D=2: bin=0, 9, 10, 59 in back-to-back requests (start asserted on each done cycle). Expect bcd=8'h00, 8'h09, 8'h10, 8'h59, each exactly 7 cycles apart.
3. Start bin=42; re-assert start with bin=7 two cycles later. Expect the second start ignored, bcd=8'h42, and a single done pulse.
4. Start bin=50; assert reset asynchronously mid-cycle 3 cycles later. Expect bcd=0, busy=0, done=0 immediately, and no done pulse after reset release.
5. N=4, D=2, chained to a 4-bit down-counter q: start every time done pulses. Each completed bcd must equal the decimal of the sampled q, covering 15->0 and the wrap to 15 (8'h15 ... 8'h00, 8'h15).
6. With BCD_AUTO_EN defined and bin held at 37: start held 0. Expect a done pulse every 7 cycles and bcd=8'h37.
